// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks (collision detector, ball
// updater, paddles, renderer).
//   - game_state_t : top-level game phase
//   - PONG_*       : field, ball and paddle geometry in pixels
//   - sum_width()  : width that holds coordinate + size sums without wrap
package pong_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        SCORED     = 2'd1,
        SERVE_WAIT = 2'd2
    } game_state_t;

    localparam int PONG_X_W           = 10;
    localparam int PONG_Y_W           = 10;
    localparam int PONG_SCREEN_W      = 640;
    localparam int PONG_SCREEN_H      = 480;
    localparam int PONG_BALL_SIZE     = 8;
    localparam int PONG_PADDLE_W      = 8;
    localparam int PONG_PADDLE_H      = 64;
    localparam int PONG_LEFT_PADDLE_X = 16;
    localparam int PONG_RIGHT_PADDLE_X = 616;
    localparam int PONG_GOAL_MARGIN   = 2;

    // One bit wider than the wider coordinate so that coordinate + size
    // comparisons never wrap.
    function automatic int sum_width(input int x_w, input int y_w);
        return ((x_w > y_w) ? x_w : y_w) + 1;
    endfunction

endpackage

// File: rtl/collision_detector_rect_overlap.sv
// rect_overlap: combinational test of the ball square against one paddle.
// The x test is inclusive on both edges, the y test exclusive, so a ball
// resting exactly on the paddle's top or bottom edge does not count.
//   ball_x, ball_y : ball top-left corner
//   paddle_y       : paddle top edge (paddle x is fixed by PADDLE_X)
//   hit            : rectangles overlap
module rect_overlap
    import pong_pkg::*;
#(
    parameter int X_W       = PONG_X_W,
    parameter int Y_W       = PONG_Y_W,
    parameter int BALL_SIZE = PONG_BALL_SIZE,
    parameter int PADDLE_W  = PONG_PADDLE_W,
    parameter int PADDLE_H  = PONG_PADDLE_H,
    parameter int PADDLE_X  = PONG_LEFT_PADDLE_X
) (
    input  logic [X_W-1:0] ball_x,
    input  logic [Y_W-1:0] ball_y,
    input  logic [Y_W-1:0] paddle_y,
    output logic           hit
);

    localparam int SUM_W = sum_width(X_W, Y_W);

    localparam logic [SUM_W-1:0] PX_LO  = SUM_W'(PADDLE_X);
    localparam logic [SUM_W-1:0] PX_HI  = SUM_W'(PADDLE_X + PADDLE_W);
    localparam logic [SUM_W-1:0] BALL   = SUM_W'(BALL_SIZE);
    localparam logic [SUM_W-1:0] PH     = SUM_W'(PADDLE_H);

    logic [SUM_W-1:0] bx, by, py;
    logic [SUM_W-1:0] bx_end, by_end, py_end;

    assign bx     = {{(SUM_W-X_W){1'b0}}, ball_x};
    assign by     = {{(SUM_W-Y_W){1'b0}}, ball_y};
    assign py     = {{(SUM_W-Y_W){1'b0}}, paddle_y};
    assign bx_end = bx + BALL;
    assign by_end = by + BALL;
    assign py_end = py + PH;

    assign hit = (bx <= PX_HI) && (bx_end >= PX_LO) &&
                 (by_end > py)  && (by < py_end);

endmodule

// File: rtl/collision_detector.sv
// collision_detector: per-frame classification of the ball against walls,
// paddles and goal lines, producing one-cycle event strobes for the ball
// updater and the score/serve logic.
//   clk, reset       : clock, synchronous active-high reset
//   tick             : frame strobe; all evaluation happens on it
//   ball_x, ball_y   : ball top-left corner
//   left_paddle_y    : left paddle top edge
//   right_paddle_y   : right paddle top edge
//   touching_paddle  : pulse, reverse x direction
//   touching_wall    : pulse, reverse y direction
//   score_left       : pulse, ball left the field on the right
//   score_right      : pulse, ball left the field on the left
//   ball_hold        : level, keep ball centred (SCORED / SERVE_WAIT)
//   serve            : pulse, release the ball
module collision_detector
    import pong_pkg::*;
#(
    parameter int X_W            = PONG_X_W,
    parameter int Y_W            = PONG_Y_W,
    parameter int SCREEN_W       = PONG_SCREEN_W,
    parameter int SCREEN_H       = PONG_SCREEN_H,
    parameter int BALL_SIZE      = PONG_BALL_SIZE,
    parameter int PADDLE_W       = PONG_PADDLE_W,
    parameter int PADDLE_H       = PONG_PADDLE_H,
    parameter int LEFT_PADDLE_X  = PONG_LEFT_PADDLE_X,
    parameter int RIGHT_PADDLE_X = PONG_RIGHT_PADDLE_X,
    parameter int GOAL_MARGIN    = PONG_GOAL_MARGIN,
    parameter int COOLDOWN       = 4,
    parameter int SERVE_DELAY    = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [X_W-1:0] ball_x,
    input  logic [Y_W-1:0] ball_y,
    input  logic [Y_W-1:0] left_paddle_y,
    input  logic [Y_W-1:0] right_paddle_y,
    output logic           touching_paddle,
    output logic           touching_wall,
    output logic           score_left,
    output logic           score_right,
    output logic           ball_hold,
    output logic           serve
);

    localparam int SUM_W = sum_width(X_W, Y_W);
    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int CD_W  = $clog2(COOLDOWN + 1);

    localparam logic [SUM_W-1:0] C_SCREEN_W   = SUM_W'(SCREEN_W);
    localparam logic [SUM_W-1:0] C_SCREEN_H   = SUM_W'(SCREEN_H);
    localparam logic [SUM_W-1:0] C_BALL       = SUM_W'(BALL_SIZE);
    localparam logic [SUM_W-1:0] C_GOAL_LEFT  = SUM_W'(GOAL_MARGIN);
    localparam logic [SUM_W-1:0] C_GOAL_RIGHT = SUM_W'(SCREEN_W - GOAL_MARGIN);
    localparam logic [SUM_W-1:0] C_WALL_TOP   = SUM_W'(1);
    localparam logic [SUM_W-1:0] C_WALL_BOT   = SUM_W'(SCREEN_H - 1);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(COOLDOWN);

    // Counts down to zero and stays there.
    function automatic logic [CD_W-1:0] sat_dec(input logic [CD_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    game_state_t      state;
    logic [CNT_W-1:0] serve_cnt;
    logic [CD_W-1:0]  wall_cd;
    logic [CD_W-1:0]  paddle_cd;

    logic [SUM_W-1:0] bx_p0, by_p0, bx_end_p0, by_end_p0;
    logic             left_hit_p0, right_hit_p0;
    logic             left_out_p0, right_out_p0, wall_hit_p0, paddle_hit_p0;

    // ---- classification of the current inputs (combinational) ----
    assign bx_p0     = {{(SUM_W-X_W){1'b0}}, ball_x};
    assign by_p0     = {{(SUM_W-Y_W){1'b0}}, ball_y};
    assign bx_end_p0 = bx_p0 + C_BALL;
    assign by_end_p0 = by_p0 + C_BALL;

    // x >= SCREEN_W means the ball decremented past 0 and wrapped.
    assign left_out_p0  = (bx_p0 <= C_GOAL_LEFT) || (bx_p0 >= C_SCREEN_W);
    assign right_out_p0 = (bx_end_p0 >= C_GOAL_RIGHT) && (bx_p0 < C_SCREEN_W);
    assign wall_hit_p0  = (by_p0 <= C_WALL_TOP) || (by_end_p0 >= C_WALL_BOT) ||
                          (by_p0 >= C_SCREEN_H);

    rect_overlap #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .BALL_SIZE(BALL_SIZE),
        .PADDLE_W (PADDLE_W),
        .PADDLE_H (PADDLE_H),
        .PADDLE_X (LEFT_PADDLE_X)
    ) u_left_overlap (
        .ball_x  (ball_x),
        .ball_y  (ball_y),
        .paddle_y(left_paddle_y),
        .hit     (left_hit_p0)
    );

    rect_overlap #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .BALL_SIZE(BALL_SIZE),
        .PADDLE_W (PADDLE_W),
        .PADDLE_H (PADDLE_H),
        .PADDLE_X (RIGHT_PADDLE_X)
    ) u_right_overlap (
        .ball_x  (ball_x),
        .ball_y  (ball_y),
        .paddle_y(right_paddle_y),
        .hit     (right_hit_p0)
    );

    assign paddle_hit_p0 = left_hit_p0 || right_hit_p0;

    // ---- registered state, cooldowns and output pulses ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= SERVE_WAIT;
            serve_cnt       <= '0;
            wall_cd         <= '0;
            paddle_cd       <= '0;
            touching_paddle <= 1'b0;
            touching_wall   <= 1'b0;
            score_left      <= 1'b0;
            score_right     <= 1'b0;
            serve           <= 1'b0;
            ball_hold       <= 1'b1;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            touching_paddle <= 1'b0;
            touching_wall   <= 1'b0;
            score_left      <= 1'b0;
            score_right     <= 1'b0;
            serve           <= 1'b0;

            if (tick) begin
                // Later assignments below (reload or clear) take precedence.
                wall_cd   <= sat_dec(wall_cd);
                paddle_cd <= sat_dec(paddle_cd);

                case (state)
                    PLAY: begin
                        if (left_out_p0) begin
                            score_right <= 1'b1;
                            state       <= SCORED;
                            ball_hold   <= 1'b1;
                        end else if (right_out_p0) begin
                            score_left  <= 1'b1;
                            state       <= SCORED;
                            ball_hold   <= 1'b1;
                        end else begin
                            // Wall and paddle are independent so a corner
                            // contact fires both in the same cycle.
                            if (wall_hit_p0 && (wall_cd == '0)) begin
                                touching_wall <= 1'b1;
                                wall_cd       <= CD_LOAD;
                            end
                            if (paddle_hit_p0 && (paddle_cd == '0)) begin
                                touching_paddle <= 1'b1;
                                paddle_cd       <= CD_LOAD;
                            end
                        end
                    end
                    SCORED: begin
                        state     <= SERVE_WAIT;
                        serve_cnt <= '0;
                        ball_hold <= 1'b1;
                    end
                    SERVE_WAIT: begin
                        if (serve_cnt == SERVE_LAST) begin
                            serve     <= 1'b1;
                            state     <= PLAY;
                            ball_hold <= 1'b0;
                            wall_cd   <= '0;
                            paddle_cd <= '0;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= SERVE_WAIT;
                        serve_cnt <= '0;
                        ball_hold <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
